// File: rtl/therm_temp_conv.sv
// Thermistor ADC code to temperature converter.
// Converts an ADC code to a signed temperature (LSB = 1/16 degC). The top
// four code bits select one segment of a 17-point calibration table. The
// remaining fraction bits interpolate linearly between the two end points
// of that segment, using a shift-add multiply.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           request handshake (accept in IDLE only)
//   in_ch, in_code              channel tag and ADC code of the request
//   out_valid/out_ready         result handshake
//   out_ch, out_temp            channel tag and saturated temperature
//   out_alarm                   {above ALARM_HI, below ALARM_LO}
//   out_err                     request tag was >= N_CH
//   lut_we, lut_addr, lut_data  calibration table write port
module therm_temp_conv #(
  parameter int unsigned ADC_W = 8,
  parameter int unsigned TEMP_W = 12,
  parameter int unsigned N_CH = 4,
  parameter logic signed [TEMP_W-1:0] ALARM_HI = 12'sd1280,
  parameter logic signed [TEMP_W-1:0] ALARM_LO = -12'sd160,
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [ADC_W-1:0]         in_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [TEMP_W-1:0] out_temp,
  output logic [1:0]               out_alarm,
  output logic                     out_err,
  input  logic                     lut_we,
  input  logic [4:0]               lut_addr,
  input  logic [TEMP_W-1:0]        lut_data
);

  localparam int unsigned F     = ADC_W - 4;
  localparam int unsigned DW    = TEMP_W + 1;
  localparam int unsigned PW    = TEMP_W + 1 + F;
  localparam int unsigned SW    = TEMP_W + 2;
  localparam int unsigned CNT_W = $clog2(F + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, MULT, DONE} state_t;

  state_t state, state_nxt;

  logic [CH_W-1:0]          ch_q;
  logic [ADC_W-1:0]         code_q;
  logic                     err_q;
  logic signed [TEMP_W-1:0] lut [0:16];
  logic signed [TEMP_W-1:0] t_lo;
  logic signed [PW-1:0]     md;
  logic signed [PW-1:0]     acc;
  logic [F-1:0]             mr;
  logic [CNT_W-1:0]         cnt;

  logic                     accept;
  logic                     in_ready_d;
  logic                     out_valid_d;
  logic [4:0]               idx_lo;
  logic [4:0]               idx_hi;
  logic signed [DW-1:0]     diff;
  logic signed [DW-1:0]     quot;
  logic signed [SW-1:0]     sum;
  logic signed [TEMP_W-1:0] temp_sat;
  logic [1:0]               alarm;

  assign accept = (state == IDLE) && in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = MULT;
      MULT:    if (cnt == CNT_W'(F)) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state.
  // in_ready therefore rises one edge after DONE is left, or after reset.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_nxt == IDLE) in_ready_d  = 1'b1;
    if (state_nxt == DONE) out_valid_d = 1'b1;
  end

  // Calibration table; addresses above 16 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 17; k++) lut[k] <= '0;
    end else if (lut_we && (lut_addr <= 5'd16)) begin
      lut[lut_addr] <= lut_data;
    end
  end

  // Segment end points, interpolation sum and saturation
  always_comb begin
    idx_lo = 5'(code_q[ADC_W-1:F]);
    idx_hi = idx_lo + 5'd1;
    diff   = {lut[idx_hi][TEMP_W-1], lut[idx_hi]} - {lut[idx_lo][TEMP_W-1], lut[idx_lo]};
    // The arithmetic shift gives floor division by 2^F.
    quot   = DW'(acc >>> F);
    sum    = {{2{t_lo[TEMP_W-1]}}, t_lo} + {quot[DW-1], quot};
    if ((sum[SW-1:TEMP_W-1] == '0) || (sum[SW-1:TEMP_W-1] == '1))
      temp_sat = sum[TEMP_W-1:0];
    else if (sum[SW-1])
      temp_sat = {1'b1, {(TEMP_W-1){1'b0}}};
    else
      temp_sat = {1'b0, {(TEMP_W-1){1'b1}}};
    alarm = {temp_sat > ALARM_HI, temp_sat < ALARM_LO};
  end

  // Request capture, table latch, shift-add multiply and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q      <= '0;
      code_q    <= '0;
      err_q     <= 1'b0;
      t_lo      <= '0;
      md        <= '0;
      acc       <= '0;
      mr        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_temp  <= '0;
      out_alarm <= '0;
      out_err   <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      case (state)
        IDLE: begin
          if (accept) begin
            ch_q   <= in_ch;
            code_q <= in_code;
            err_q  <= 32'(in_ch) >= N_CH;
          end
        end
        LOOKUP: begin
          // Snapshot of the segment; later table writes cannot disturb it.
          t_lo <= lut[idx_lo];
          md   <= {{F{diff[DW-1]}}, diff};
          mr   <= code_q[F-1:0];
          acc  <= '0;
          cnt  <= '0;
        end
        MULT: begin
          if (cnt != CNT_W'(F)) begin
            if (mr[0]) acc <= acc + md;
            md  <= md <<< 1;
            mr  <= mr >> 1;
            cnt <= cnt + CNT_W'(1);
          end else begin
            out_ch    <= ch_q;
            out_err   <= err_q;
            out_temp  <= err_q ? '0 : temp_sat;
            out_alarm <= err_q ? 2'b00 : alarm;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_therm_temp_conv.sv
// Bench for therm_temp_conv: a 4-channel and a 3-channel build share the
// stimulus. Expected results are queued at accept time and checked by
// per-instance monitors when each result is handed over.
module tb_therm_temp_conv;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [1:0]        in_ch;
  logic [7:0]        in_code;
  logic              out_ready;
  logic              lut_we;
  logic [4:0]        lut_addr;
  logic [11:0]       lut_data;

  logic              in_ready, out_valid, out_err;
  logic [1:0]        out_ch, out_alarm;
  logic signed [11:0] out_temp;
  logic              in_ready3, out_valid3, out_err3;
  logic [1:0]        out_ch3, out_alarm3;
  logic signed [11:0] out_temp3;

  typedef struct {
    logic [1:0] ch;
    int         temp;
    logic [1:0] alarm;
    logic       err;
    int         acc;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  therm_temp_conv #(.ADC_W(8), .TEMP_W(12), .N_CH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_code(in_code), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_temp(out_temp),
    .out_alarm(out_alarm), .out_err(out_err), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_data(lut_data)
  );

  therm_temp_conv #(.ADC_W(8), .TEMP_W(12), .N_CH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_ch(in_ch), .in_code(in_code), .out_valid(out_valid3),
    .out_ready(out_ready), .out_ch(out_ch3), .out_temp(out_temp3),
    .out_alarm(out_alarm3), .out_err(out_err3), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_data(lut_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 4-channel build
  always @(negedge clk) begin : mon4
    exp_t e;
    logic prev;
    if (rst) prev = 1'b0;
    else begin
      if (out_valid && !prev) begin
        if (q4.size() == 0) chk("n4_unexpected_valid", 1, 0);
        else chk("n4_latency", cyc - q4[0].acc, 6);
      end
      if (out_valid && out_ready) begin
        if (q4.size() == 0) chk("n4_unexpected_result", 1, 0);
        else begin
          e = q4.pop_front();
          chk("n4_temp", int'(out_temp), e.temp);
          chk("n4_alarm", int'(out_alarm), int'(e.alarm));
          chk("n4_ch", int'(out_ch), int'(e.ch));
          chk("n4_err", int'(out_err), int'(e.err));
        end
      end
      prev = out_valid;
    end
  end

  // Monitor for the 3-channel build
  always @(negedge clk) begin : mon3
    exp_t e;
    logic prev;
    if (rst) prev = 1'b0;
    else begin
      if (out_valid3 && !prev) begin
        if (q3.size() == 0) chk("n3_unexpected_valid", 1, 0);
        else chk("n3_latency", cyc - q3[0].acc, 6);
      end
      if (out_valid3 && out_ready) begin
        if (q3.size() == 0) chk("n3_unexpected_result", 1, 0);
        else begin
          e = q3.pop_front();
          chk("n3_temp", int'(out_temp3), e.temp);
          chk("n3_alarm", int'(out_alarm3), int'(e.alarm));
          chk("n3_ch", int'(out_ch3), int'(e.ch));
          chk("n3_err", int'(out_err3), int'(e.err));
        end
      end
      prev = out_valid3;
    end
  end

  task automatic lut_write(input logic [4:0] addr, input int data);
    lut_we   = 1'b1;
    lut_addr = addr;
    lut_data = 12'(data);
    @(posedge clk); #1;
    lut_we   = 1'b0;
  endtask

  // Issue one request (called #1 after a rising edge); queue its expectations.
  task automatic issue(input logic [1:0] ch, input logic [7:0] code,
                       input int temp, input logic [1:0] alarm, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
    end else begin
      in_valid = 1'b1;
      in_ch    = ch;
      in_code  = code;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (push) begin
        q4.push_back('{ch, temp, alarm, 1'b0, cyc});
        if (ch >= 2'd3) q3.push_back('{ch, 0, 2'b00, 1'b1, cyc});
        else            q3.push_back('{ch, temp, alarm, 1'b0, cyc});
      end
    end
  endtask

  initial begin
    int n;
    in_valid = 1'b0; in_ch = '0; in_code = '0; out_ready = 1'b1;
    lut_we = 1'b0; lut_addr = '0; lut_data = '0;
    rst = 1'b1;
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_temp", int'(out_temp), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_alarm", int'(out_alarm), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_in_ready3", int'(in_ready3), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("in_ready_before_edge", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("in_ready_after_rst", int'(in_ready), 1);

    // Calibration points
    lut_write(5'd0, 1500);  lut_write(5'd1, 0);
    lut_write(5'd3, 400);   lut_write(5'd4, 320);
    lut_write(5'd5, 1280);  lut_write(5'd6, 1296);
    lut_write(5'd7, -160);  lut_write(5'd8, -176);
    lut_write(5'd9, 0);     lut_write(5'd10, -1);
    lut_write(5'd11, 0);    lut_write(5'd12, 1);
    lut_write(5'd13, 2047); lut_write(5'd14, -2048);
    lut_write(5'd15, -100); lut_write(5'd16, -200);
    lut_write(5'd20, 777);  // out-of-range address, dropped

    issue(2'd2, 8'h38, 360, 2'b00, 1'b1);
    issue(2'd1, 8'hFF, -194, 2'b01, 1'b1);
    issue(2'd3, 8'h3F, 325, 2'b00, 1'b1);
    issue(2'd0, 8'h08, 750, 2'b00, 1'b1);
    issue(2'd1, 8'h50, 1280, 2'b00, 1'b1);
    issue(2'd2, 8'h51, 1281, 2'b10, 1'b1);
    issue(2'd0, 8'h70, -160, 2'b00, 1'b1);
    issue(2'd3, 8'h71, -161, 2'b01, 1'b1);
    issue(2'd1, 8'h91, -1, 2'b00, 1'b1);
    issue(2'd2, 8'hBF, 0, 2'b00, 1'b1);
    issue(2'd0, 8'hD8, -1, 2'b00, 1'b1);

    // Write on the accept edge is seen; write on the LOOKUP edge is not.
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    lut_we = 1'b1; lut_addr = 5'd11; lut_data = 12'd160;
    issue(2'd1, 8'hB0, 160, 2'b00, 1'b1);
    lut_data = 12'd999;
    @(posedge clk); #1;
    lut_we = 1'b0;

    // Output stall: result held, no new request accepted
    issue(2'd0, 8'h00, 1500, 2'b10, 1'b1);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("stall_valid_seen", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_temp", int'(out_temp), 1500);
      chk("stall_alarm", int'(out_alarm), 2);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;

    // Reset during MULT aborts the conversion and clears the table
    issue(2'd2, 8'h38, 0, 2'b00, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_out_temp", int'(out_temp), 0);
    q4.delete();
    q3.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_abort", int'(in_ready), 1);
    issue(2'd2, 8'h38, 0, 2'b00, 1'b1);
    issue(2'd3, 8'h3F, 0, 2'b00, 1'b1);

    n = 0;
    while ((q4.size() != 0 || q3.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_q4", q4.size(), 0);
    chk("drain_q3", q3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/therm_temp_conv.md
THERM_TEMP_CONV -- requirements
Module: therm_temp_conv

Interface
REQ-001 SHALL have parameter ADC_W, default 8: thermistor ADC code width; minimum 5.
REQ-002 SHALL have parameter TEMP_W, default 12: signed temperature width; LSB = 1/16 degC.
REQ-003 SHALL have parameter N_CH, default 4: number of thermistor channels; minimum 1.
REQ-004 SHALL have parameter ALARM_HI, default 12'sd1280 (80 degC): upper alarm threshold, TEMP_W signed.
REQ-005 SHALL have parameter ALARM_LO, default -12'sd160 (-10 degC): lower alarm threshold, TEMP_W signed.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  conversion request.
REQ-009 SHALL have port in_ready  output  1  block can accept a request.
REQ-010 SHALL have port in_ch  input  max(1,$clog2(N_CH))  channel tag.
REQ-011 SHALL have port in_code  input  ADC_W  thermistor voltage code.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port out_ch  output  in_ch width  channel tag of result.
REQ-015 SHALL have port out_temp  output  TEMP_W  signed temperature.
REQ-016 SHALL have port out_alarm  output  2  bit1 = above ALARM_HI, bit0 = below ALARM_LO.
REQ-017 SHALL have port out_err  output  1  request carried in_ch >= N_CH.
REQ-018 SHALL have ports lut_we input 1, lut_addr input 5, lut_data input TEMP_W: calibration table write.

Function
REQ-019 SHALL hold a 17-entry signed calibration table T[0..16]; write on clk when lut_we=1 and lut_addr<=16; addr 17..31 ignored.
REQ-020 SHALL let F = ADC_W-4; segment i = in_code[ADC_W-1:F]; fraction f = in_code[F-1:0].
REQ-021 SHALL compute temp = T[i] + floor(((T[i+1]-T[i]) * f) / 2^F), difference held at TEMP_W+1 bits, product at TEMP_W+1+F bits, arithmetic shift right.
REQ-022 SHALL saturate temp to TEMP_W signed range before output.
REQ-023 SHALL implement the FSM IDLE -> LOOKUP -> MULT -> DONE -> IDLE.
REQ-024 SHALL drive in_ready=1 only in IDLE; a request is accepted on an edge with in_valid & in_ready, capturing in_ch and in_code.
REQ-025 SHALL, in LOOKUP (1 cycle), latch T[i] and T[i+1]; table writes after this cycle do not affect the in-flight conversion.
REQ-026 SHALL perform the multiply in MULT as F-cycle shift-add (no hard multiplier).
REQ-027 SHALL assert out_valid in DONE, exactly F+2 cycles after the accepting edge; out_* stable while out_valid & !out_ready.
REQ-028 SHALL leave DONE on out_valid & out_ready; in_ready rises the following cycle (no same-cycle accept).
REQ-029 SHALL set out_alarm[1] = temp > ALARM_HI and out_alarm[0] = temp < ALARM_LO (strict), from the saturated value.
REQ-030 SHALL, when in_ch >= N_CH, still run full latency, output out_temp=0, out_alarm=0, out_err=1.
REQ-031 SHALL treat lut_we concurrent with a request as write-first for LOOKUP only if the write edge precedes LOOKUP.

Reset
REQ-032 SHALL, on rst=1, asynchronously enter IDLE, abort any conversion, clear all T[] to 0, and drive out_valid=0, out_temp=0, out_ch=0, out_alarm=0, out_err=0, in_ready=0 while rst=1.
REQ-033 SHALL raise in_ready on the first clk edge after rst deasserts.

Verification (ADC_W=8, TEMP_W=12, N_CH=4)
REQ-034 SHALL cover: T[3]=400, T[4]=320, code 0x38 ch2 -> out_temp=360, out_ch=2, out_alarm=00, out_valid 6 cycles after accept.
REQ-035 SHALL cover: T[15]=-100, T[16]=-200, code 0xFF -> diff -100 * 15 = -1500, floor/16 = -94 -> out_temp=-194, out_alarm=01.
REQ-036 SHALL cover: T[0]=1500, code 0x00 -> out_temp=1500, out_alarm=10; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-037 SHALL cover: in_ch=5 equivalent via N_CH=4 tag 3 valid vs forced out-of-range build N_CH=3, tag 3 -> out_err=1, out_temp=0.
REQ-038 SHALL cover: rst pulse during MULT -> out_valid=0 immediately, table reads 0, next request code 0x38 -> out_temp=0.
